pipeline_hazard_unit: RTL and testbench
=======================================

Name: pipeline_hazard_unit

Overview:
Hazard and stall controller for the 5-stage pipelined MIPS core. It is the producer of the Bubble input consumed by the pipelined control decoder.
- Watches ID/EX and IF/ID instruction fields.
- Drives PC/IF-ID write enables, Bubble and the PC source select.
- Covers load-use stalls, jump squash and branch resolve-in-EX stalls.
- Keeps a saturating count of bubble cycles for performance measurement.

Parameters:
COUNT_W, 16, width of the bubble-cycle performance counter.

Ports:
CLK  in  1  pipeline clock, rising edge.
Reset_L  in  1  reset, asynchronous, active-low.
IDEX_MemRead  in  1  instruction in EX is a load.
IDEX_Rt  in  5  destination register of the load in EX.
IFID_Rs  in  5  rs field of the instruction in ID.
IFID_Rt  in  5  rt field of the instruction in ID.
IFID_UsesRs  in  1  ID instruction reads rs.
IFID_UsesRt  in  1  ID instruction reads rt (R-type, sw, beq).
IFID_Jump  in  1  ID instruction is j.
IFID_Branch  in  1  ID instruction is beq.
EX_BranchTaken  in  1  branch in EX resolved taken; valid only in state BR_WAIT.
PCWrite  out  1  enable PC update.
IFWrite  out  1  enable IF/ID register update.
Bubble  out  1  zero the control word entering ID/EX.
AddrSel  out  2  PC source select: 00 PC+4, 01 jump target, 10 branch target.
StallCount  out  COUNT_W  number of cycles with Bubble=1 since reset; saturates.

Behaviour:
General:
- Single clock CLK. Reset_L is asynchronous, active-low.
- FSM states: RUN, JMP_SQ, BR_WAIT, BR_SQ. Outputs are Mealy (functions of state and inputs).
- While Reset_L=0:
  - state=RUN, StallCount=0.
  - Outputs forced to PCWrite=0, IFWrite=0, Bubble=1, AddrSel=00.
- Load-use hazard (LU): IDEX_MemRead && IDEX_Rt!=0 && ((IFID_UsesRs && IFID_Rs==IDEX_Rt) || (IFID_UsesRt && IFID_Rt==IDEX_Rt)).
- Register 0 never causes a hazard.
RUN, in priority order:
- LU: PCWrite=0, IFWrite=0, Bubble=1, AddrSel=00; stay RUN. LU has priority over Jump and Branch; the jump/branch is re-evaluated next cycle.
- IFID_Jump: PCWrite=1, AddrSel=01, IFWrite=0, Bubble=0; go to JMP_SQ.
- IFID_Branch: PCWrite=0, IFWrite=0, Bubble=0 (branch issues to EX); go to BR_WAIT.
- Otherwise: PCWrite=1, IFWrite=1, Bubble=0, AddrSel=00.
- If IFID_Jump and IFID_Branch are both set, Jump wins.
JMP_SQ:
- IF/ID still holds the jump, which must not be re-issued.
- Bubble=1, PCWrite=1, IFWrite=1, AddrSel=00 (fetch the target); go to RUN.
BR_WAIT:
- Branch is in EX; Bubble=1.
- EX_BranchTaken=1: PCWrite=1, AddrSel=10, IFWrite=0; go to BR_SQ.
- EX_BranchTaken=0: PCWrite=1, IFWrite=1, AddrSel=00; go to RUN. The held PC equals branch+4, so the fall-through instruction is fetched.
BR_SQ:
- Bubble=1, PCWrite=1, IFWrite=1, AddrSel=00; go to RUN.
Penalties:
- Load-use: 1 bubble per stall cycle.
- Jump: 1 bubble.
- Branch not taken: 1 bubble.
- Branch taken: 2 bubbles.
StallCount:
- Increments on each rising edge with Bubble=1 and Reset_L=1.
- Holds at 2^COUNT_W-1; no wrap.
Reset mid-operation:
- Asserting Reset_L low in any state returns to RUN immediately, with outputs forced as above.
- The first cycle after release behaves as RUN.
Unused states: unreachable encodings decode to RUN with the RUN default outputs.

Decomposition:
Shared package hazard_pkg:
- FSM state encoding: RUN=2'b00, JMP_SQ=2'b01, BR_WAIT=2'b10, BR_SQ=2'b11.
- AddrSel constants: ADDR_PC4=2'b00, ADDR_JUMP=2'b01, ADDR_BRANCH=2'b10.
Sub-module load_use_detect: purely combinational LU comparator, reused later by forwarding logic. FSM and counter stay in the top module.

Test Plan:
1. Load-use stall: lw $2 in EX (IDEX_MemRead=1, IDEX_Rt=2); ID add with Rs=2, UsesRs=1 -> exactly one cycle of PCWrite=0, IFWrite=0, Bubble=1; then normal; StallCount 0->1.
2. $0 filter and unused operand: IDEX_Rt=0 with IFID_Rs=0, UsesRs=1 -> no stall. IDEX_Rt=5, IFID_Rt=5, UsesRt=0 -> no stall.
3. Jump: IFID_Jump=1 in RUN -> cycle 1: AddrSel=01, PCWrite=1, IFWrite=0, Bubble=0; cycle 2: Bubble=1, IFWrite=1, AddrSel=00; then RUN.
4. Branch taken and not taken:
   - Taken: IFID_Branch=1, then EX_BranchTaken=1 -> BR_WAIT with AddrSel=10, then BR_SQ; Bubble=1 for 2 cycles.
   - Not taken: EX_BranchTaken=0 -> 1 bubble, AddrSel=00, back to RUN.
5. Priorities:
   - LU and IFID_Branch both set -> stall first, branch issued next cycle.
   - IFID_Jump=1 and IFID_Branch=1 -> jump path taken.
6. Reset and saturation:
   - Drop Reset_L in BR_WAIT -> outputs forced immediately (Bubble=1, PCWrite=0) and state RUN after release.
   - With COUNT_W=3, hold LU for 10 cycles -> StallCount stops at 7.

Source files
------------

// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared encodings for the pipeline hazard unit:
// FSM states and PC source select values.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        JMP_SQ  = 2'b01,
        BR_WAIT = 2'b10,
        BR_SQ   = 2'b11
    } state_t;

    localparam logic [1:0] ADDR_PC4    = 2'b00;
    localparam logic [1:0] ADDR_JUMP   = 2'b01;
    localparam logic [1:0] ADDR_BRANCH = 2'b10;

endpackage

// File: rtl/pipeline_hazard_unit_if.sv
// Bundle between the pipeline datapath and the hazard unit:
// IF/ID and ID/EX fields in, stall and PC-steering controls out.
interface pipeline_hazard_unit_if #(
    parameter int COUNT_W = 16
);
    logic               IDEX_MemRead;
    logic [4:0]         IDEX_Rt;
    logic [4:0]         IFID_Rs;
    logic [4:0]         IFID_Rt;
    logic               IFID_UsesRs;
    logic               IFID_UsesRt;
    logic               IFID_Jump;
    logic               IFID_Branch;
    logic               EX_BranchTaken;
    logic               PCWrite;
    logic               IFWrite;
    logic               Bubble;
    logic [1:0]         AddrSel;
    logic [COUNT_W-1:0] StallCount;

    modport master (
        output IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt,
        output IFID_UsesRs, IFID_UsesRt, IFID_Jump,
        output IFID_Branch, EX_BranchTaken,
        input  PCWrite, IFWrite, Bubble, AddrSel, StallCount
    );

    modport slave (
        input  IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt,
        input  IFID_UsesRs, IFID_UsesRt, IFID_Jump,
        input  IFID_Branch, EX_BranchTaken,
        output PCWrite, IFWrite, Bubble, AddrSel, StallCount
    );
endinterface

// File: rtl/pipeline_hazard_unit_load_use_detect.sv
// Combinational load-use comparator; $0 never creates a hazard.
module load_use_detect (
    input  logic       mem_read,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       uses_rs,
    input  logic       uses_rt,
    output logic       hazard
);
    logic rs_hit;
    logic rt_hit;

    assign rs_hit = uses_rs && (id_rs == ex_rt);
    assign rt_hit = uses_rt && (id_rt == ex_rt);
    assign hazard = mem_read && (ex_rt != 5'd0) && (rs_hit || rt_hit);
endmodule

// File: rtl/pipeline_hazard_unit.sv
// Stall/squash controller: load-use, jump squash, branch resolve in EX,
// plus a saturating bubble-cycle counter.
module pipeline_hazard_unit
    import hazard_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic                 CLK,
    input  logic                 Reset_L,
    pipeline_hazard_unit_if.slave hz
);
    state_t             state;
    state_t             state_nx;
    logic               lu;
    logic               pc_write;
    logic               if_write;
    logic               bubble;
    logic [1:0]         addr_sel;
    logic [COUNT_W-1:0] count;

    load_use_detect u_lu (
        .mem_read (hz.IDEX_MemRead),
        .ex_rt    (hz.IDEX_Rt),
        .id_rs    (hz.IFID_Rs),
        .id_rt    (hz.IFID_Rt),
        .uses_rs  (hz.IFID_UsesRs),
        .uses_rt  (hz.IFID_UsesRt),
        .hazard   (lu)
    );

    always_comb begin
        pc_write = 1'b1;
        if_write = 1'b1;
        bubble   = 1'b0;
        addr_sel = ADDR_PC4;
        state_nx = RUN;
        case (state)
            RUN: begin
                if (lu) begin
                    pc_write = 1'b0;
                    if_write = 1'b0;
                    bubble   = 1'b1;
                end else if (hz.IFID_Jump) begin
                    if_write = 1'b0;
                    addr_sel = ADDR_JUMP;
                    state_nx = JMP_SQ;
                end else if (hz.IFID_Branch) begin
                    pc_write = 1'b0;
                    if_write = 1'b0;
                    state_nx = BR_WAIT;
                end
            end
            JMP_SQ: begin
                bubble = 1'b1;
            end
            BR_WAIT: begin
                bubble = 1'b1;
                // Not-taken falls through: held PC is already branch+4.
                if (hz.EX_BranchTaken) begin
                    if_write = 1'b0;
                    addr_sel = ADDR_BRANCH;
                    state_nx = BR_SQ;
                end
            end
            BR_SQ: begin
                bubble = 1'b1;
            end
            default: begin
                state_nx = RUN;
            end
        endcase
        if (!Reset_L) begin
            pc_write = 1'b0;
            if_write = 1'b0;
            bubble   = 1'b1;
            addr_sel = ADDR_PC4;
            state_nx = RUN;
        end
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state <= RUN;
            count <= '0;
        end else begin
            state <= state_nx;
            if (bubble && (count != {COUNT_W{1'b1}}))
                count <= count + 1'b1;
        end
    end

    assign hz.PCWrite    = pc_write;
    assign hz.IFWrite    = if_write;
    assign hz.Bubble     = bubble;
    assign hz.AddrSel    = addr_sel;
    assign hz.StallCount = count;
endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Scoreboard bench: directed steps push expected controls,
// which are popped and compared once the outputs settle.
module tb_pipeline_hazard_unit;

    typedef struct {
        logic       pcw;
        logic       ifw;
        logic       bub;
        logic [1:0] addr;
        string      tag;
    } exp_t;

    logic       CLK;
    logic       Reset_L;
    logic       mr;
    logic [4:0] ex_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       jmp;
    logic       br;
    logic       tk;

    int   checks;
    int   errors;
    int   exp_cnt;
    int   exp_cnt3;
    exp_t sb[$];

    pipeline_hazard_unit_if #(.COUNT_W(16)) hif ();
    pipeline_hazard_unit_if #(.COUNT_W(3))  hif3 ();

    assign hif.IDEX_MemRead    = mr;
    assign hif.IDEX_Rt         = ex_rt;
    assign hif.IFID_Rs         = rs;
    assign hif.IFID_Rt         = rt;
    assign hif.IFID_UsesRs     = urs;
    assign hif.IFID_UsesRt     = urt;
    assign hif.IFID_Jump       = jmp;
    assign hif.IFID_Branch     = br;
    assign hif.EX_BranchTaken  = tk;
    assign hif3.IDEX_MemRead   = mr;
    assign hif3.IDEX_Rt        = ex_rt;
    assign hif3.IFID_Rs        = rs;
    assign hif3.IFID_Rt        = rt;
    assign hif3.IFID_UsesRs    = urs;
    assign hif3.IFID_UsesRt    = urt;
    assign hif3.IFID_Jump      = jmp;
    assign hif3.IFID_Branch    = br;
    assign hif3.EX_BranchTaken = tk;

    pipeline_hazard_unit #(.COUNT_W(16)) dut (
        .CLK     (CLK),
        .Reset_L (Reset_L),
        .hz      (hif)
    );

    pipeline_hazard_unit #(.COUNT_W(3)) dut_sat (
        .CLK     (CLK),
        .Reset_L (Reset_L),
        .hz      (hif3)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, push expectation, compare 1ns later.
    task automatic step(input string tag, input logic r,
                        input logic i_mr, input logic [4:0] i_ex,
                        input logic [4:0] i_rs, input logic [4:0] i_rt,
                        input logic i_urs, input logic i_urt,
                        input logic i_j, input logic i_b, input logic i_tk,
                        input logic e_pcw, input logic e_ifw,
                        input logic e_bub, input logic [1:0] e_addr);
        exp_t e;
        exp_t g;
        @(negedge CLK);
        Reset_L = r;
        mr = i_mr; ex_rt = i_ex; rs = i_rs; rt = i_rt;
        urs = i_urs; urt = i_urt; jmp = i_j; br = i_b; tk = i_tk;
        if (!r) begin
            exp_cnt  = 0;
            exp_cnt3 = 0;
        end
        e.pcw = e_pcw; e.ifw = e_ifw; e.bub = e_bub;
        e.addr = e_addr; e.tag = tag;
        sb.push_back(e);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            g = sb.pop_front();
            chk({g.tag, ".PCWrite"}, 32'(hif.PCWrite), 32'(g.pcw));
            chk({g.tag, ".IFWrite"}, 32'(hif.IFWrite), 32'(g.ifw));
            chk({g.tag, ".Bubble"}, 32'(hif.Bubble), 32'(g.bub));
            chk({g.tag, ".AddrSel"}, 32'(hif.AddrSel), 32'(g.addr));
            chk({g.tag, ".Bubble3"}, 32'(hif3.Bubble), 32'(g.bub));
            chk({g.tag, ".StallCount"}, 32'(hif.StallCount), exp_cnt);
            chk({g.tag, ".StallCount3"}, 32'(hif3.StallCount), exp_cnt3);
            if (r && g.bub) begin
                exp_cnt++;
                if (exp_cnt3 < 7) exp_cnt3++;
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0; exp_cnt = 0; exp_cnt3 = 0;
        Reset_L = 1'b0;
        mr = 0; ex_rt = 0; rs = 0; rt = 0;
        urs = 0; urt = 0; jmp = 0; br = 0; tk = 0;

        // reset: forced outputs
        step("rst", 0, 0,0,0,0,0,0, 0,0,0, 0,0,1,2'b00);
        step("rst_lu", 0, 1,2,2,0,1,0, 0,0,0, 0,0,1,2'b00);

        // load-use one cycle, then normal
        step("lu", 1, 1,2,2,0,1,0, 0,0,0, 0,0,1,2'b00);
        step("lu_after", 1, 0,2,2,0,1,0, 0,0,0, 1,1,0,2'b00);

        // $0 filter and unused operand
        step("r0", 1, 1,0,0,0,1,0, 0,0,0, 1,1,0,2'b00);
        step("unused_rt", 1, 1,5,0,5,0,0, 0,0,0, 1,1,0,2'b00);
        step("lu_rt", 1, 1,7,0,7,0,1, 0,0,0, 0,0,1,2'b00);

        // jump squash
        step("jmp1", 1, 0,0,0,0,0,0, 1,0,0, 1,0,0,2'b01);
        step("jmp2", 1, 0,0,0,0,0,0, 1,0,0, 1,1,1,2'b00);
        step("jmp3", 1, 0,0,0,0,0,0, 0,0,0, 1,1,0,2'b00);

        // branch taken: two bubbles
        step("bt_issue", 1, 0,0,0,0,0,0, 0,1,0, 0,0,0,2'b00);
        step("bt_wait", 1, 0,0,0,0,0,0, 0,1,1, 1,0,1,2'b10);
        step("bt_sq", 1, 0,0,0,0,0,0, 0,0,0, 1,1,1,2'b00);
        step("bt_run", 1, 0,0,0,0,0,0, 0,0,0, 1,1,0,2'b00);

        // branch not taken: one bubble
        step("bn_issue", 1, 0,0,0,0,0,0, 0,1,0, 0,0,0,2'b00);
        step("bn_wait", 1, 0,0,0,0,0,0, 0,1,0, 1,1,1,2'b00);
        step("bn_run", 1, 0,0,0,0,0,0, 0,0,0, 1,1,0,2'b00);

        // LU beats branch; branch re-evaluated next cycle
        step("lu_br", 1, 1,3,3,0,1,0, 0,1,0, 0,0,1,2'b00);
        step("lu_br_iss", 1, 0,3,3,0,1,0, 0,1,0, 0,0,0,2'b00);
        step("lu_br_wait", 1, 0,0,0,0,0,0, 0,0,0, 1,1,1,2'b00);

        // jump beats branch
        step("jb1", 1, 0,0,0,0,0,0, 1,1,0, 1,0,0,2'b01);
        step("jb2", 1, 0,0,0,0,0,0, 1,1,0, 1,1,1,2'b00);
        step("jb3", 1, 0,0,0,0,0,0, 0,0,0, 1,1,0,2'b00);

        // reset in BR_WAIT, then RUN after release
        step("rb_issue", 1, 0,0,0,0,0,0, 0,1,0, 0,0,0,2'b00);
        step("rb_rst", 0, 0,0,0,0,0,0, 0,1,1, 0,0,1,2'b00);
        step("rb_run", 1, 0,0,0,0,0,0, 0,0,1, 1,1,0,2'b00);

        // saturation: COUNT_W=3 stops at 7, 16-bit keeps counting
        for (int i = 0; i < 10; i++)
            step("sat_lu", 1, 1,9,9,0,1,0, 0,0,0, 0,0,1,2'b00);
        step("sat_end", 1, 0,0,0,0,0,0, 0,0,0, 1,1,0,2'b00);
        chk("sat_cnt3", 32'(hif3.StallCount), 32'd7);
        chk("sat_cnt16", 32'(hif.StallCount), 32'd10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
